// File: rtl/reg_wr_arbiter_if.sv
// reg_wr_arbiter_if
//   Bundles the requester side and the register-write side of the shared
//   data-register write port arbiter.
//   Signals:
//     req    [NREQ]        per-requester write request
//     lock   [NREQ]        per-requester burst lock (only meaningful with req)
//     wdata  [NREQ*WIDTH]  requester data, requester i at [i*WIDTH +: WIDTH]
//     gnt    [NREQ]        one-hot registered grant
//     owner  [3]           index of granted requester, valid while busy
//     busy                 a grant is active this cycle
//     reg_en               register enable
//     reg_d  [WIDTH]       register D
//   Modports: master = requesters/observer side, slave = arbiter side.
interface reg_wr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       lock;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [2:0]            owner;
   logic                  busy;
   logic                  reg_en;
   logic [WIDTH-1:0]      reg_d;

   modport master (
      output req, lock, wdata,
      input  gnt, owner, busy, reg_en, reg_d
   );

   modport slave (
      input  req, lock, wdata,
      output gnt, owner, busy, reg_en, reg_d
   );
endinterface

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
//   Shares the D/en write port of one data register between NREQ requesters.
//   Round-robin arbitration with a registered one-hot grant; a requester
//   holding req+lock keeps the grant for up to MAXHOLD consecutive cycles.
//   Ports:
//     clk    in   rising-edge clock
//     res_n  in   asynchronous active-low reset
//     bus    slave modport of reg_wr_arbiter_if (req/lock/wdata in,
//            gnt/owner/busy/reg_en/reg_d out)
//   Build option:
//     REGARB_FIXED_PRIO_EN  defined -> fixed priority, lowest index wins;
//                           undefined -> round-robin (default).
module reg_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int MAXHOLD = 4
) (
   input logic             clk,
   input logic             res_n,
   reg_wr_arbiter_if.slave bus
);

   localparam int unsigned NREQ_U    = NREQ;
   localparam logic [3:0]  MAXHOLD_C = 4'(MAXHOLD);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [2:0]      owner_q, owner_d;
   logic [3:0]      hold_q, hold_d;

   logic            win_vld;
   logic [2:0]      win_idx;
   logic            own_req;
   logic            own_lock;
   logic [WIDTH-1:0] reg_d_mux;
   logic            busy;

   // Current owner's request/lock and data slice.
   always_comb begin
      own_req   = 1'b0;
      own_lock  = 1'b0;
      reg_d_mux = bus.wdata[WIDTH-1:0];
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         if (owner_q == 3'(i)) begin
            own_req   = bus.req[i];
            own_lock  = bus.lock[i];
            reg_d_mux = bus.wdata[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef REGARB_FIXED_PRIO_EN
   // Lowest requesting index wins; no rotation state.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         if (!win_vld && bus.req[i]) begin
            win_vld = 1'b1;
            win_idx = 3'(i);
         end
      end
   end
`else
   logic [2:0] ptr_q, ptr_d;

   // Search starts just after the last winner, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int unsigned k = 1; k <= NREQ_U; k++) begin
         idx = (32'(ptr_q) + k) % NREQ_U;
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win_idx = 3'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         ptr_q <= 3'(NREQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Every exit path (idle, single grant, burst end) shares one arbiter;
   // ptr already equals the owner, so a finished burst gets lowest priority.
   always_comb begin
      logic arb;
      arb     = 1'b0;
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      hold_d  = hold_q;
`ifndef REGARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: arb = 1'b1;
         GRANT: begin
            if (own_req && own_lock && (MAXHOLD_C > 4'd1)) begin
               state_d = LOCKED;
               hold_d  = hold_q + 4'd1;
            end else begin
               arb = 1'b1;
            end
         end
         LOCKED: begin
            if (own_req && own_lock && (hold_q < MAXHOLD_C)) begin
               hold_d = hold_q + 4'd1;
            end else begin
               arb = 1'b1;
            end
         end
         default: arb = 1'b1;
      endcase

      if (arb) begin
         if (win_vld) begin
            state_d = GRANT;
            owner_d = win_idx;
            hold_d  = 4'd1;
            for (int unsigned i = 0; i < NREQ_U; i++) begin
               gnt_d[i] = (win_idx == 3'(i));
            end
`ifndef REGARB_FIXED_PRIO_EN
            ptr_d = win_idx;
`endif
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign bus.gnt    = gnt_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = busy;
   assign bus.reg_en = busy & own_req;
   assign bus.reg_d  = reg_d_mux;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter
//   Table of per-cycle vectors (inputs + expected outputs) queued as they are
//   driven and checked at the following falling edge, then a stretch of
//   random traffic checked against grant invariants.
module tb_reg_wr_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int MAXHOLD = 4;
   localparam logic [31:0] W = 32'hD3C2B1A5;

   logic clk   = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   reg_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   reg_wr_arbiter #(
      .NREQ   (NREQ),
      .WIDTH  (WIDTH),
      .MAXHOLD(MAXHOLD)
   ) dut (
      .clk  (clk),
      .res_n(res_n),
      .bus  (bus)
   );

   // The data register fed by the arbiter.
   logic [7:0] ext_q;
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)          ext_q <= '0;
      else if (bus.reg_en) ext_q <= bus.reg_d;
   end

   typedef struct {
      logic       rn;
      logic [3:0] req;
      logic [3:0] lock;
      logic [3:0] gnt;
      logic       busy;
      logic [2:0] owner;
      logic       en;
      logic [7:0] d;
      logic       od;     // owner/reg_d meaningful this row
      logic [7:0] q;
   } vec_t;

   vec_t tbl[35];
   vec_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(logic rn, logic [3:0] rq, logic [3:0] lk,
                               logic [3:0] g, logic b, logic [2:0] o,
                               logic e, logic [7:0] dd, logic od, logic [7:0] q);
      vec_t v;
      v.rn = rn; v.req = rq; v.lock = lk; v.gnt = g; v.busy = b;
      v.owner = o; v.en = e; v.d = dd; v.od = od; v.q = q;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t e;
      //            rn req      lock     gnt      b o e d     od q
      tbl[0]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[1]  = mk(1, 4'b0001, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[2]  = mk(1, 4'b0001, 4'b0000, 4'b0001, 1,0,1,8'hA5,1,8'h00);
      tbl[3]  = mk(1, 4'b1111, 4'b0000, 4'b0001, 1,0,1,8'hA5,1,8'hA5);
      tbl[4]  = mk(1, 4'b1111, 4'b0000, 4'b0010, 1,1,1,8'hB1,1,8'hA5);
      tbl[5]  = mk(1, 4'b1111, 4'b0000, 4'b0100, 1,2,1,8'hC2,1,8'hB1);
      tbl[6]  = mk(1, 4'b1111, 4'b0000, 4'b1000, 1,3,1,8'hD3,1,8'hC2);
      tbl[7]  = mk(1, 4'b1111, 4'b0000, 4'b0001, 1,0,1,8'hA5,1,8'hD3);
      tbl[8]  = mk(1, 4'b0011, 4'b0001, 4'b0010, 1,1,1,8'hB1,1,8'hA5);
      tbl[9]  = mk(1, 4'b0011, 4'b0001, 4'b0001, 1,0,1,8'hA5,1,8'hB1);
      tbl[10] = mk(1, 4'b0011, 4'b0001, 4'b0001, 1,0,1,8'hA5,1,8'hA5);
      tbl[11] = mk(1, 4'b0011, 4'b0001, 4'b0001, 1,0,1,8'hA5,1,8'hA5);
      tbl[12] = mk(1, 4'b0011, 4'b0001, 4'b0001, 1,0,1,8'hA5,1,8'hA5);
      tbl[13] = mk(1, 4'b0011, 4'b0001, 4'b0010, 1,1,1,8'hB1,1,8'hA5);
      tbl[14] = mk(1, 4'b0011, 4'b0001, 4'b0001, 1,0,1,8'hA5,1,8'hB1);
      tbl[15] = mk(1, 4'b0100, 4'b0000, 4'b0001, 1,0,0,8'hA5,1,8'hA5);
      tbl[16] = mk(1, 4'b1010, 4'b0000, 4'b0100, 1,2,0,8'hC2,1,8'hA5);
      tbl[17] = mk(1, 4'b1010, 4'b0000, 4'b1000, 1,3,1,8'hD3,1,8'hA5);
      tbl[18] = mk(1, 4'b0000, 4'b0000, 4'b0010, 1,1,0,8'hB1,1,8'hD3);
      tbl[19] = mk(1, 4'b0000, 4'b0000, 4'b0000, 0,0,0,8'h00,0,8'hD3);
      tbl[20] = mk(1, 4'b0010, 4'b0010, 4'b0000, 0,0,0,8'h00,0,8'hD3);
      tbl[21] = mk(1, 4'b0010, 4'b0010, 4'b0010, 1,1,1,8'hB1,1,8'hD3);
      tbl[22] = mk(1, 4'b0010, 4'b0010, 4'b0010, 1,1,1,8'hB1,1,8'hB1);
      tbl[23] = mk(0, 4'b1111, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[24] = mk(1, 4'b1111, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[25] = mk(1, 4'b1111, 4'b0000, 4'b0001, 1,0,1,8'hA5,1,8'h00);
      tbl[26] = mk(0, 4'b1000, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[27] = mk(1, 4'b1000, 4'b0000, 4'b0000, 0,0,0,8'hA5,1,8'h00);
      tbl[28] = mk(1, 4'b1001, 4'b0000, 4'b1000, 1,3,1,8'hD3,1,8'h00);
      tbl[29] = mk(1, 4'b1001, 4'b0000, 4'b0001, 1,0,1,8'hA5,1,8'hD3);
      tbl[30] = mk(1, 4'b0000, 4'b0000, 4'b1000, 1,3,0,8'hD3,1,8'hA5);
      tbl[31] = mk(1, 4'b0000, 4'b1111, 4'b0000, 0,0,0,8'h00,0,8'hA5);
      tbl[32] = mk(1, 4'b0100, 4'b1011, 4'b0000, 0,0,0,8'h00,0,8'hA5);
      tbl[33] = mk(1, 4'b0000, 4'b0100, 4'b0100, 1,2,0,8'hC2,1,8'hA5);
      tbl[34] = mk(1, 4'b0000, 4'b0000, 4'b0000, 0,0,0,8'h00,0,8'hA5);

      bus.req   = '0;
      bus.lock  = '0;
      bus.wdata = W;
      res_n     = 1'b0;
      #2;

      for (int k = 0; k < 35; k++) begin
         @(posedge clk);
         #1;
         res_n    = tbl[k].rn;
         bus.req  = tbl[k].req;
         bus.lock = tbl[k].lock;
         sb.push_back(tbl[k]);
         @(negedge clk);
         if (sb.size() == 0) begin
            chk($sformatf("r%0d scoreboard empty", k), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("r%0d gnt", k),    32'(bus.gnt),    32'(e.gnt));
            chk($sformatf("r%0d busy", k),   32'(bus.busy),   32'(e.busy));
            chk($sformatf("r%0d reg_en", k), 32'(bus.reg_en), 32'(e.en));
            chk($sformatf("r%0d reg_q", k),  32'(ext_q),      32'(e.q));
            if (e.od) begin
               chk($sformatf("r%0d owner", k), 32'(bus.owner), 32'(e.owner));
               chk($sformatf("r%0d reg_d", k), 32'(bus.reg_d), 32'(e.d));
            end else begin
               chk($sformatf("r%0d reg_d known", k),
                   32'($isunknown(bus.reg_d)), 32'd0);
            end
         end
      end

      // Random traffic: one-hot grant, busy/enable/data consistency.
      for (int c = 0; c < 60; c++) begin
         logic [7:0] want_d;
         logic       one_hit;
         @(posedge clk);
         #1;
         bus.req   = 4'($urandom);
         bus.lock  = 4'($urandom);
         bus.wdata = $urandom;
         @(negedge clk);
         want_d  = '0;
         one_hit = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
               want_d  = bus.wdata[i*WIDTH +: WIDTH];
               one_hit = (bus.owner == 3'(i));
            end
         end
         chk("rand onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
         chk("rand busy",   32'(bus.busy),   32'(bus.gnt != '0));
         chk("rand reg_en", 32'(bus.reg_en), 32'(|(bus.gnt & bus.req)));
         if (bus.gnt != '0) begin
            chk("rand owner", 32'(one_hit),   32'd1);
            chk("rand reg_d", 32'(bus.reg_d), 32'(want_d));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
